// File: rtl/rf_pkg.sv
// Shared defaults, architectural register indices and port-slicing helpers
// for the multi-port integer register file.
package rf_pkg;

    localparam int unsigned XLEN_DEF  = 32;
    localparam int unsigned NREGS_DEF = 32;
    localparam int unsigned AW_DEF    = $clog2(NREGS_DEF);

    localparam int unsigned REG_ZERO = 0;
    localparam int unsigned REG_SP   = 2;

    // Low bit of field k in a flattened vector of w-bit fields
    function automatic int unsigned port_lo(input int unsigned k, input int unsigned w);
        return k * w;
    endfunction

    // High bit of field k in a flattened vector of w-bit fields
    function automatic int unsigned port_hi(input int unsigned k, input int unsigned w);
        return (k * w) + w - 1;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register. Flush beats
// issue, and issue beats a writeback clear on the same register. x0 is never pending.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int unsigned NREGS = NREGS_DEF,
    parameter int unsigned AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             iss_en,
    input  logic [AW-1:0]    iss_a,
    input  logic             clr_en,
    input  logic [AW-1:0]    clr_a,
    output logic [NREGS-1:0] pend
);

    logic [NREGS-1:0] pend_nxt;
    logic             set_hit;
    logic             clr_hit;

    assign set_hit = iss_en && (iss_a != AW'(REG_ZERO));
    assign clr_hit = clr_en && (clr_a != AW'(REG_ZERO));

    // Clear first so that a same-address set overrides it
    always_comb begin
        pend_nxt = pend;
        if (flush) begin
            pend_nxt = '0;
        end else begin
            if (clr_hit) begin
                pend_nxt[clr_a] = 1'b0;
            end
            if (set_hit) begin
                pend_nxt[iss_a] = 1'b1;
            end
        end
        pend_nxt[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= '0;
        end else begin
            pend <= pend_nxt;
        end
    end

endmodule

// File: rtl/rf_multiport.sv
// Parametrised integer register file with NRD combinational read ports, a
// posedge write port and a pending-write scoreboard. Define RF_BYPASS_EN to
// forward the WB write data (and its scoreboard clear) to same-cycle reads.
module rf_multiport
    import rf_pkg::*;
#(
    parameter int unsigned     XLEN    = XLEN_DEF,
    parameter int unsigned     NREGS   = NREGS_DEF,
    parameter int unsigned     AW      = $clog2(NREGS),
    parameter int unsigned     NRD     = 2,
    parameter logic [XLEN-1:0] SP_INIT = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NRD*AW-1:0]   ra,
    output logic [NRD*XLEN-1:0] rd,
    output logic [NRD-1:0]      rbusy,
    input  logic                we,
    input  logic [AW-1:0]       wa,
    input  logic [XLEN-1:0]     wd,
    input  logic                iss_en,
    input  logic [AW-1:0]       iss_a,
    input  logic                flush
);

    if ((NRD < 1) || (NRD > 4)) begin : g_bad_nrd
        $error("rf_multiport: NRD must be in 1..4");
    end
    if ((NREGS < 2) || (NREGS != (1 << AW))) begin : g_bad_nregs
        $error("rf_multiport: NREGS must be a power of two >= 2 equal to 2**AW");
    end

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] pend;
    logic             wr_hit;

    assign wr_hit = we && (wa != AW'(REG_ZERO));

    rf_scoreboard #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_sb (
        .clk    (clk),
        .rst_n  (rst_n),
        .flush  (flush),
        .iss_en (iss_en),
        .iss_a  (iss_a),
        .clr_en (we),
        .clr_a  (wa),
        .pend   (pend)
    );

    // Architectural array; x0 is reset to zero and never written
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs[i] <= (i == REG_SP) ? SP_INIT : '0;
            end
        end else if (wr_hit) begin
            regs[wa] <= wd;
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        localparam int unsigned ALO = port_lo(k, AW);
        localparam int unsigned DLO = port_lo(k, XLEN);

        logic [AW-1:0] a;
        logic          a_nz;

        assign a    = ra[ALO +: AW];
        assign a_nz = (a != AW'(REG_ZERO));

`ifdef RF_BYPASS_EN
        logic hit;
        logic reissue;

        // A same-cycle writeback both supplies the data and retires the
        // pending bit, unless a newer producer is issuing to the same register
        assign hit      = wr_hit && (a == wa);
        assign reissue  = iss_en && !flush && (iss_a == a);
        assign rd[DLO +: XLEN] = hit ? wd : regs[a];
        assign rbusy[k] = pend[a] && a_nz && (!hit || reissue);
`else
        assign rd[DLO +: XLEN] = regs[a];
        assign rbusy[k] = pend[a] && a_nz;
`endif
    end

endmodule
